adder: RTL and testbench

ADDER -- requirements
Module: adder

---
 rtl/adder_pkg.sv | 5 +
 rtl/adder_cla4.sv | 28 ++
 rtl/adder.sv | 71 +++++++
 tb/tb_adder.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared constants for the registered carry-lookahead adder
package adder_pkg;
    localparam int ADDER_WIDTH_DEFAULT = 8;
    localparam int CLA_BLOCK           = 4;
endpackage

// File: rtl/adder_cla4.sv
// rtl/adder_cla4.sv - one 4-bit carry-lookahead block with group generate/propagate
module adder_cla4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       g,
    output logic       p
);
    logic [3:0] w_g;
    logic [3:0] w_p;
    logic [3:0] w_c;

    assign w_g = a & b;
    assign w_p = a ^ b;

    // Internal carries expanded so no bit ripples through its neighbour.
    assign w_c[0] = cin;
    assign w_c[1] = w_g[0] | (w_p[0] & cin);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & cin);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & cin);

    assign s = w_p ^ w_c;
    assign g = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
             | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
    assign p = &w_p;
endmodule

// File: rtl/adder.sv
// rtl/adder.sv - registered WIDTH-bit CLA adder; ADDER_OVERFLOW_EN adds a signed overflow flag
module adder
    import adder_pkg::*;
#(
    parameter int WIDTH = ADDER_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             carry_in,
    output logic [WIDTH-1:0] sum,
`ifdef ADDER_OVERFLOW_EN
    output logic             overflow,
`endif
    output logic             carry_output_bit
);
    localparam int NB = WIDTH / CLA_BLOCK;

    logic [NB:0]        w_gc;
    logic [NB-1:0]      w_bg;
    logic [NB-1:0]      w_bp;
    logic [WIDTH-1:0]   w_sum_next;
    logic [WIDTH-1:0]   r_sum;
    logic               r_carry;

    assign w_gc[0] = carry_in;

    // Group carries ripple block-to-block; each block resolves its own bits in parallel.
    for (genvar k = 0; k < NB; k++) begin : g_blk
        adder_cla4 u_cla4 (
            .a   (x[k*CLA_BLOCK +: CLA_BLOCK]),
            .b   (y[k*CLA_BLOCK +: CLA_BLOCK]),
            .cin (w_gc[k]),
            .s   (w_sum_next[k*CLA_BLOCK +: CLA_BLOCK]),
            .g   (w_bg[k]),
            .p   (w_bp[k])
        );
        assign w_gc[k+1] = w_bg[k] | (w_bp[k] & w_gc[k]);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sum   <= '0;
            r_carry <= 1'b0;
        end else begin
            r_sum   <= w_sum_next;
            r_carry <= w_gc[NB];
        end
    end

    assign sum              = r_sum;
    assign carry_output_bit = r_carry;

`ifdef ADDER_OVERFLOW_EN
    logic w_ovf_next;
    logic r_overflow;

    assign w_ovf_next = (x[WIDTH-1] == y[WIDTH-1]) && (w_sum_next[WIDTH-1] != x[WIDTH-1]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= w_ovf_next;
        end
    end

    assign overflow = r_overflow;
`endif
endmodule

// File: tb/tb_adder.sv
// tb/tb_adder.sv - table-driven self-checking bench for adder
module tb_adder;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         carry_in;
    logic [W-1:0] sum;
    logic         carry_output_bit;
`ifdef ADDER_OVERFLOW_EN
    logic         overflow;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic         cin;
        logic [W-1:0] exp_sum;
        logic         exp_c;
        logic         exp_ov;
    } vec_t;

    vec_t vecs [$];

    adder #(.WIDTH(W)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .x                (x),
        .y                (y),
        .carry_in         (carry_in),
        .sum              (sum),
`ifdef ADDER_OVERFLOW_EN
        .overflow         (overflow),
`endif
        .carry_output_bit (carry_output_bit)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        x        = a;
        y        = b;
        carry_in = c;
    endtask

    task automatic add_vec(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                           input logic [W-1:0] es, input logic ec, input logic eo);
        vec_t v;
        v.x = a; v.y = b; v.cin = c; v.exp_sum = es; v.exp_c = ec; v.exp_ov = eo;
        vecs.push_back(v);
    endtask

    initial begin
        add_vec(8'd1,   8'd2,   1'b0, 8'd3,   1'b0, 1'b0);
        add_vec(8'd255, 8'd1,   1'b0, 8'd0,   1'b1, 1'b0);
        add_vec(8'd255, 8'd255, 1'b1, 8'd255, 1'b1, 1'b0);
        add_vec(8'h0F,  8'h01,  1'b0, 8'h10,  1'b0, 1'b0);
        add_vec(8'd10,  8'd20,  1'b0, 8'd30,  1'b0, 1'b0);
        add_vec(8'd100, 8'd100, 1'b1, 8'd201, 1'b0, 1'b1);
        add_vec(8'd200, 8'd100, 1'b0, 8'd44,  1'b1, 1'b0);
        add_vec(8'd0,   8'd0,   1'b1, 8'd1,   1'b0, 1'b0);
        add_vec(8'hAA,  8'h55,  1'b0, 8'hFF,  1'b0, 1'b0);
        add_vec(8'hF0,  8'h10,  1'b0, 8'h00,  1'b1, 1'b0);
        add_vec(8'h77,  8'h99,  1'b0, 8'h10,  1'b1, 1'b0);
        add_vec(8'h0F,  8'hF0,  1'b1, 8'h00,  1'b1, 1'b0);
        add_vec(8'd127, 8'd1,   1'b0, 8'h80,  1'b0, 1'b1);
        add_vec(8'h80,  8'h80,  1'b0, 8'h00,  1'b1, 1'b1);
        add_vec(8'd3,   8'd4,   1'b0, 8'd7,   1'b0, 1'b0);

        // Reset with busy operands: outputs must be zero.
        rst_n = 1'b0;
        drive(8'hFF, 8'hFF, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        check("reset_sum", 64'(sum), 64'd0);
        check("reset_carry", 64'(carry_output_bit), 64'd0);
`ifdef ADDER_OVERFLOW_EN
        check("reset_ovf", 64'(overflow), 64'd0);
`endif

        // Vectors applied back-to-back, one per cycle.
        rst_n = 1'b1;
        foreach (vecs[i]) begin
            drive(vecs[i].x, vecs[i].y, vecs[i].cin);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_sum", i), 64'(sum), 64'(vecs[i].exp_sum));
            check($sformatf("vec%0d_carry", i), 64'(carry_output_bit), 64'(vecs[i].exp_c));
`ifdef ADDER_OVERFLOW_EN
            check($sformatf("vec%0d_ovf", i), 64'(overflow), 64'(vecs[i].exp_ov));
`endif
        end

        // Outputs hold between edges while inputs change.
        drive(8'd40, 8'd2, 1'b0);
        @(posedge clk);
        #1;
        drive(8'd1, 8'd1, 1'b1);
        #3;
        check("hold_sum", 64'(sum), 64'd42);
        check("hold_carry", 64'(carry_output_bit), 64'd0);
        @(posedge clk);
        #1;
        check("next_sum", 64'(sum), 64'd3);

        // One-cycle reset while x=5,y=6; result 11 one edge after release.
        rst_n = 1'b0;
        drive(8'd5, 8'd6, 1'b0);
        @(posedge clk);
        #1;
        check("midrst_sum", 64'(sum), 64'd0);
        check("midrst_carry", 64'(carry_output_bit), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("release_sum", 64'(sum), 64'd11);

        // Reset discards an in-flight carry-producing result; next result clean.
        drive(8'd200, 8'd100, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("discard_sum", 64'(sum), 64'd0);
        check("discard_carry", 64'(carry_output_bit), 64'd0);
        rst_n = 1'b1;
        drive(8'd1, 8'd2, 1'b0);
        @(posedge clk);
        #1;
        check("after_sum", 64'(sum), 64'd3);
        check("after_carry", 64'(carry_output_bit), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
